// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : RISC-V memory-access stage. Runs LB/LH/LW/LBU/LHU/SB/SH/SW over a
//            byte-serial synchronous RAM and stalls the pipeline while busy.
// Revision : 1.0
// ============================================================================
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_sdata,
  input  logic [7:0]  ram_din,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        stall_req
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  logic [1:0]  r_state;
  logic [4:0]  r_wd;
  logic        r_wreg;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [1:0]  r_cnt;
  logic [31:0] r_result;
  logic [31:0] r_ram_addr;
  logic        r_ram_wr;
  logic [7:0]  r_ram_dout;

  logic        w_ex_load;
  logic        w_ex_store;
  logic        w_ex_mem;
  logic        w_r_load;
  logic        w_r_store;
  logic [1:0]  w_last;
  logic [1:0]  w_next;
  logic [1:0]  w_cap_idx;

  // Index of the final byte of an access (N-1).
  function automatic logic [1:0] last_idx(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: last_idx = 2'd0;
      OP_LH, OP_LHU, OP_SH: last_idx = 2'd1;
      default:              last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] k);
    case (k)
      2'd0:    byte_sel = d[7:0];
      2'd1:    byte_sel = d[15:8];
      2'd2:    byte_sel = d[23:16];
      default: byte_sel = d[31:24];
    endcase
  endfunction

  assign w_ex_load  = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LHU);
  assign w_ex_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
  assign w_ex_mem   = w_ex_load || w_ex_store;
  assign w_r_load   = (r_op >= OP_LB) && (r_op <= OP_LHU);
  assign w_r_store  = (r_op >= OP_SB) && (r_op <= OP_SW);
  assign w_last     = last_idx(r_op);
  assign w_next     = r_cnt + 2'd1;
  // A load byte lands one cycle after its issue, so capture lags the issue count.
  assign w_cap_idx  = (r_state == ST_WAIT) ? w_last : (r_cnt - 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wd       <= 5'd0;
      r_wreg     <= 1'b0;
      r_op       <= 4'd0;
      r_addr     <= 32'd0;
      r_sdata    <= 32'd0;
      r_cnt      <= 2'd0;
      r_result   <= 32'd0;
      r_ram_addr <= 32'd0;
      r_ram_wr   <= 1'b0;
      r_ram_dout <= 8'd0;
    end else begin
      r_ram_addr <= 32'd0;
      r_ram_wr   <= 1'b0;
      r_ram_dout <= 8'd0;
      case (r_state)
        ST_IDLE: begin
          if (w_ex_mem) begin
            r_wd       <= ex_wd;
            r_wreg     <= ex_wreg;
            r_op       <= ex_mem_op;
            r_addr     <= ex_mem_addr;
            r_sdata    <= ex_mem_sdata;
            r_cnt      <= 2'd0;
            r_result   <= 32'd0;
            r_ram_addr <= ex_mem_addr;
            r_ram_wr   <= w_ex_store;
            r_ram_dout <= w_ex_store ? ex_mem_sdata[7:0] : 8'd0;
            r_state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (w_r_load && (r_cnt != 2'd0))
            r_result[{w_cap_idx, 3'b000} +: 8] <= ram_din;
          if (r_cnt == w_last) begin
            r_state <= w_r_load ? ST_WAIT : ST_DONE;
          end else begin
            r_cnt      <= w_next;
            r_ram_addr <= r_addr + {30'd0, w_next};
            r_ram_wr   <= w_r_store;
            r_ram_dout <= w_r_store ? byte_sel(r_sdata, w_next) : 8'd0;
          end
        end
        ST_WAIT: begin
          r_result[{w_cap_idx, 3'b000} +: 8] <= ram_din;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wd    = 5'd0;
    mem_wreg  = 1'b0;
    mem_wdata = 32'd0;
    stall_req = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ex_mem) begin
          stall_req = 1'b1;
        end else begin
          mem_wd    = ex_wd;
          mem_wreg  = ex_wreg;
          mem_wdata = ex_wdata;
        end
      end
      ST_ACCESS, ST_WAIT: stall_req = 1'b1;
      default: begin
        if (w_r_load) begin
          mem_wd   = r_wd;
          mem_wreg = r_wreg;
          case (r_op)
            OP_LB:   mem_wdata = {{24{r_result[7]}}, r_result[7:0]};
            OP_LH:   mem_wdata = {{16{r_result[15]}}, r_result[15:0]};
            OP_LBU:  mem_wdata = {24'd0, r_result[7:0]};
            OP_LHU:  mem_wdata = {16'd0, r_result[15:0]};
            default: mem_wdata = r_result;
          endcase
        end
      end
    endcase
  end

  assign ram_addr = r_ram_addr;
  assign ram_wr   = r_ram_wr;
  assign ram_dout = r_ram_dout;

endmodule
`default_nettype wire

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RISC-V pipeline, between the EX/MEM pipeline register and the MEM/WB register. It performs LB/LH/LW/LBU/LHU/SB/SH/SW over a byte-serial synchronous RAM port, sign- or zero-extends load data, and holds the pipeline with `stall_req` while the access is in flight. Non-memory instructions pass straight through to MEM/WB with zero latency.

## Interface
- Parameters: none; bus widths are 32-bit data/address (`RegBus`) and 5-bit register address (`RegAddrBus`).
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ex_wd`  in  5  destination register from EX/MEM.
- `ex_wreg`  in  1  write-enable from EX/MEM.
- `ex_wdata`  in  32  ALU result from EX/MEM.
- `ex_mem_op`  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9–15 treated as none.
- `ex_mem_addr`  in  32  effective byte address.
- `ex_mem_sdata`  in  32  store data.
- `ram_din`  in  8  read byte, valid the cycle after its address is presented.
- `ram_addr`  out  32  registered byte address.
- `ram_wr`  out  1  registered write strobe (1 = write `ram_dout` at `ram_addr`).
- `ram_dout`  out  8  registered write byte.
- `mem_wd`  out  5  to MEM/WB.
- `mem_wreg`  out  1  to MEM/WB.
- `mem_wdata`  out  32  to MEM/WB.
- `stall_req`  out  1  to pipeline control; while high, EX/MEM and all earlier stages hold.

## Operation
- States: IDLE, ACCESS, WAIT (loads only), DONE. N = 1/2/4 bytes for B/H/W.
- IDLE, op none: `mem_wd/mem_wreg/mem_wdata` = `ex_wd/ex_wreg/ex_wdata` combinationally; `stall_req`=0.
- IDLE, op load/store: `stall_req`=1; on edge latch wd, wreg, op, addr, sdata; clear counters; go ACCESS.
- ACCESS: byte k (k=0..N-1) issued in ACCESS cycle k: `ram_addr`=addr+k, store: `ram_wr`=1, `ram_dout`=sdata[8k+7:8k]. Little-endian, sequential byte addresses; no alignment check, addr+k wraps mod 2^32.
- Load: byte k sampled from `ram_din` at the end of the cycle following its issue into result[8k+7:8k]. After last issue → WAIT (captures byte N-1) → DONE. Store: after last issue → DONE.
- DONE (one cycle): `stall_req`=0; load: `mem_wd`=latched wd, `mem_wreg`=latched wreg, `mem_wdata`=result sign-extended from bit 7/15 (LB/LH), zero-extended (LBU/LHU), unchanged (LW); store: `mem_wreg`=0, `mem_wd`=0, `mem_wdata`=0. Next edge → IDLE without sampling EX inputs (EX/MEM advances on that same edge).
- In IDLE-with-mem-op, ACCESS, WAIT: `mem_wd`=0, `mem_wreg`=0, `mem_wdata`=0 (bubble into MEM/WB).
- `ram_wr`=0, `ram_addr`=0, `ram_dout`=0 in every cycle not issuing a byte; `ram_wr` never high during loads.
- Reset (any time, including mid-access): state IDLE, counters/latches/result 0, `ram_addr`=0, `ram_wr`=0, `ram_dout`=0 immediately; outputs then follow IDLE rules from current EX inputs. Aborted store leaves already-written bytes in RAM.

## Timing
- T0 = cycle the mem op appears at EX inputs (IDLE).
- Load N bytes: issues T1..TN, captures end of T2..T(N+1), WAIT at T(N+1), DONE at T(N+2); `stall_req` high T0..T(N+1). LW: 6 stall cycles, result at T6.
- Store N bytes: writes T1..TN, DONE at T(N+1); `stall_req` high T0..TN. SW: 5 stall cycles.
- Back-to-back mem ops: second op appears at T(DONE+1) in IDLE and starts a new T0; no overlap.
- Non-mem op: 0 latency, no stall.

## Test plan
- Reset: assert `rst` mid-ACCESS of SW → `ram_wr`=0, `ram_addr`=0, `stall_req` follows IDLE rules in the same cycle; release, op none passes `ex_wdata`=0x12345678, wd=5 straight through.
- SW addr 0x100, sdata 0xA1B2C3D4 → writes 0xD4@0x100, 0xC3@0x101, 0xB2@0x102, 0xA1@0x103 at T1..T4; stall T0..T4; DONE T5 with `mem_wreg`=0.
- RAM holds 0x80,0xFF at 0x200/0x201: LH wd=7 → DONE T4 `mem_wdata`=0xFFFFFF80, `mem_wreg`=1, wd=7; LHU → 0x0000FF80.
- LB of 0x9C → 0xFFFFFF9C; LBU → 0x0000009C; LW of bytes 11,22,33,44 → 0x44332211 at T6.
- Back-to-back SB then LB same address 0x300, byte 0x5A → LB returns 0x0000005A; EX inputs held throughout each stall; no spurious `ram_wr` in DONE or IDLE.
- Address wrap: SH at 0xFFFFFFFF → bytes to 0xFFFFFFFF then 0x00000000.
